// File: rtl/sr_flipflop_bank.sv
// sr_flipflop_bank: WIDTH independent clock-synchronous SR flip-flops.
// Each channel has a selectable S&R conflict policy and an enable. The bank
// shares a synchronous clear, registered rise/fall change pulses, a sticky
// conflict flag and a saturating conflict-cycle counter.
module sr_flipflop_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] en_i,
  input  logic             clr_i,
  input  logic             conflict_clr_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             conflict_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  // Reject illegal parameter values while the design is elaborated.
  if (WIDTH < 1) begin : gen_bad_width
    $error("sr_flipflop_bank: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : gen_bad_cnt_w
    $error("sr_flipflop_bank: CNT_W must be >= 1");
  end
  if ((CONFLICT_MODE < 0) || (CONFLICT_MODE > 3)) begin : gen_bad_mode
    $error("sr_flipflop_bank: CONFLICT_MODE must be 0..3");
  end

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] setOnly;
  logic [WIDTH-1:0] rstOnly;
  logic [WIDTH-1:0] bothReq;
  logic [WIDTH-1:0] plainNext;
  logic [WIDTH-1:0] resolved;
  logic             conflictEvent;

  // Per-channel next state: clear first, then enable gating, then the S/R
  // truth table with the compile-time policy applied to S&R channels.
  always_comb begin
    setOnly   = s_i & ~r_i;
    rstOnly   = r_i & ~s_i;
    bothReq   = s_i & r_i;
    plainNext = (out_q | setOnly) & ~rstOnly;
    resolved  = plainNext;
    case (CONFLICT_MODE)
      0:       resolved = plainNext & ~bothReq;
      1:       resolved = plainNext | bothReq;
      2:       resolved = plainNext;
      3:       resolved = plainNext ^ bothReq;
      default: resolved = plainNext;
    endcase
    if (clr_i) begin
      out_d = RESET_VALUE;
    end else begin
      out_d = (en_i & resolved) | (~en_i & out_q);
    end
    rise_d = ~out_q & out_d;
    fall_d = out_q & ~out_d;
  end

  // Conflict monitor: an event cycle beats a simultaneous conflict_clr, and
  // the counter stops at all-ones instead of wrapping.
  always_comb begin
    conflictEvent = (|(s_i & r_i & en_i)) & ~clr_i;
    conflict_d    = conflict_q;
    cnt_d         = cnt_q;
    if (conflictEvent) begin
      conflict_d = 1'b1;
      if (conflict_clr_i) begin
        cnt_d = CntOne;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end
    end else if (conflict_clr_i) begin
      conflict_d = 1'b0;
      cnt_d      = '0;
    end
  end

  // State and pulse registers; reset loads RESET_VALUE with no pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q      <= RESET_VALUE;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_o          = out_q;
  assign rise_o         = rise_q;
  assign fall_o         = fall_q;
  assign conflict_o     = conflict_q;
  assign conflict_cnt_o = cnt_q;

endmodule
